// File: rtl/const_materializer.sv
// Turns a 32-bit constant and a destination register into the shortest MIPS
// load sequence (ADDIU, LUI, or LUI+ORI), streamed one word per handshake.
module const_materializer #(
    parameter bit EMIT_NOP_FOR_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD1 = 2'd1,
        WORD2 = 2'd2
    } state_t;

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    state_t      state, state_nx;
    logic [31:0] instr_q, instr_nx;
    logic [15:0] lo_q, lo_nx;
    logic [4:0]  rt_q, rt_nx;
    logic        two_q, two_nx;

    logic accept;
    logic handshake;
    logic fits16;

    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state != IDLE);
    assign out_instr = instr_q;
    assign out_last  = (state == WORD2) || ((state == WORD1) && !two_q);

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    // Bits 31:15 uniform means the value survives sign extension of a 16-bit immediate.
    assign fits16    = (&in_value[31:15]) || !(|in_value[31:15]);

    // NOTE: every output of this block is given a hold default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        instr_nx = instr_q;
        lo_nx    = lo_q;
        rt_nx    = rt_q;
        two_nx   = two_q;

        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lo_nx  = in_value[15:0];
                        rt_nx  = in_rt;
                        two_nx = 1'b0;
                        if (in_rt == 5'd0) begin
                            if (EMIT_NOP_FOR_R0) begin
                                instr_nx = 32'h0000_0000;
                                state_nx = WORD1;
                            end
                        end else if (fits16) begin
                            instr_nx = {OP_ADDIU, 5'd0, in_rt, in_value[15:0]};
                            state_nx = WORD1;
                        end else if (in_value[15:0] == 16'h0000) begin
                            instr_nx = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
                            state_nx = WORD1;
                        end else begin
                            instr_nx = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
                            two_nx   = 1'b1;
                            state_nx = WORD1;
                        end
                    end
                end
                WORD1: begin
                    if (handshake) begin
                        if (two_q) begin
                            instr_nx = {OP_ORI, rt_q, rt_q, lo_q};
                            state_nx = WORD2;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                WORD2: begin
                    if (handshake) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            instr_q <= 32'h0000_0000;
            lo_q    <= 16'h0000;
            rt_q    <= 5'd0;
            two_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            instr_q <= instr_nx;
            lo_q    <= lo_nx;
            rt_q    <= rt_nx;
            two_q   <= two_nx;
        end
    end

endmodule

// File: tb/tb_const_materializer.sv
// Scoreboard bench for const_materializer: stimulus pushes hand-computed words,
// a negedge monitor pops and compares on every retired output word.
module tb_const_materializer;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    logic        in_valid1;
    logic        in_ready1;
    logic        out_valid1;
    logic [31:0] out_instr1;
    logic        out_last1;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    const_materializer #(.EMIT_NOP_FOR_R0(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_last(out_last)
    );

    const_materializer #(.EMIT_NOP_FOR_R0(1'b1)) dut_nop (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_value(in_value), .in_rt(in_rt),
        .out_valid(out_valid1), .out_ready(1'b1),
        .out_instr(out_instr1), .out_last(out_last1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic last);
        exp_t e;
        e.instr = instr;
        e.last  = last;
        sb.push_back(e);
    endtask

    // Presents a command and returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] v, input logic [4:0] r);
        int n = 0;
        in_value = v;
        in_rt    = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: any word retired by the DUT must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got %h with nothing expected at %0t", out_instr, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_last", {31'b0, out_last}, {31'b0, e.last});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        in_value  = 32'h0;
        in_rt     = 5'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_instr", out_instr, 32'h0);
        check("reset_out_last", {31'b0, out_last}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single-word commands.
        expect_word(32'h2408_1234, 1'b1); send(32'h0000_1234, 5'd8);  drain();
        expect_word(32'h2409_8000, 1'b1); send(32'hFFFF_8000, 5'd9);  drain();
        expect_word(32'h3C0A_1234, 1'b1); send(32'h1234_0000, 5'd10); drain();
        expect_word(32'h2401_0000, 1'b1); send(32'h0000_0000, 5'd1);  drain();

        // Sign boundary: both need LUI+ORI.
        expect_word(32'h3C02_0000, 1'b0); expect_word(32'h3442_8000, 1'b1);
        send(32'h0000_8000, 5'd2); drain();
        expect_word(32'h3C03_FFFF, 1'b0); expect_word(32'h3463_7FFF, 1'b1);
        send(32'hFFFF_7FFF, 5'd3); drain();

        // Two-word command under 3 cycles of backpressure.
        out_ready = 1'b0;
        expect_word(32'h3C04_1234, 1'b0); expect_word(32'h3484_5678, 1'b1);
        send(32'h1234_5678, 5'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_instr", out_instr, 32'h3C04_1234);
            check("stall_last", {31'b0, out_last}, 32'd0);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("w1_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("w2_valid", {31'b0, out_valid}, 32'd1);
        check("w2_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("post_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_valid", {31'b0, out_valid}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;

        // rt = 0 dropped by the default instance.
        send(32'h0000_1234, 5'd0);
        @(negedge clk);
        check("r0_drop_valid", {31'b0, out_valid}, 32'd0);
        check("r0_drop_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // rt = 0 turned into a NOP by the second instance.
        in_value  = 32'h0000_1234;
        in_rt     = 5'd0;
        in_valid1 = 1'b1;
        @(negedge clk);
        check("nop_in_ready", {31'b0, in_ready1}, 32'd1);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        check("nop_valid", {31'b0, out_valid1}, 32'd1);
        check("nop_instr", out_instr1, 32'h0);
        check("nop_last", {31'b0, out_last1}, 32'd1);
        @(negedge clk);
        check("nop_once", {31'b0, out_valid1}, 32'd0);
        @(posedge clk);
        #1;

        // Flush during WORD2, with a handshake and a new command in the same cycle.
        out_ready = 1'b0;
        expect_word(32'h3C05_1234, 1'b0);
        send(32'h1234_5678, 5'd5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_value = 32'h0000_0077;
        in_rt    = 5'd7;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        expect_word(32'h2408_1234, 1'b1); send(32'h0000_1234, 5'd8); drain();

        // Asynchronous reset between edges while in WORD1.
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd6);
        @(negedge clk);
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_instr", out_instr, 32'h0);
        check("async_rst_last", {31'b0, out_last}, 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_word(32'h3C0A_1234, 1'b1); send(32'h1234_0000, 5'd10); drain();

        check("final_sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/const_materializer.md
# const_materializer

Converts a 32-bit constant plus a destination register number into the shortest MIPS instruction sequence that loads it: ADDIU, LUI, or LUI followed by ORI. It performs the inverse of immediate sign extension, narrowing a full-width value into 16-bit immediate fields. The block sits in front of the fetch/decode stage on the debug and boot-injection path. It delivers instruction words one at a time over a valid/ready stream.

## Interface
- EMIT_NOP_FOR_R0, default 0. 0: a command with rt = 0 is consumed and produces no output. 1: such a command emits one NOP (0x00000000) with out_last = 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  command present.
- in_ready  output  1  command accepted when in_valid && in_ready.
- in_value  input  32  constant to materialize.
- in_rt  input  5  destination register.
- out_valid  output  1  out_instr holds a valid instruction word.
- out_ready  input  1  consumer accepts the word.
- out_instr  output  32  registered instruction word.
- out_last  output  1  high on the final word of the current command.

## Operation
- Instruction encodings:
  - ADDIU = {6'h09, 5'd0, rt, imm16}
  - LUI = {6'h0F, 5'd0, rt, imm16}
  - ORI = {6'h0D, rt, rt, imm16}
- Classification, evaluated on the accept cycle in priority order:
  - If in_value[31:15] is all zeros or all ones (fits signed 16): one word, ADDIU rt, $0, in_value[15:0]. Value 0 therefore yields ADDIU.
  - Else if in_value[15:0] == 0: one word, LUI rt, in_value[31:16].
  - Else: two words, LUI rt, hi, then ORI rt, rt, lo.
- The rt = 0 rule from EMIT_NOP_FOR_R0 overrides this classification.
- States and transitions:
  - IDLE: on accept, go to WORD1 with the first word loaded. For an rt = 0 drop, stay in IDLE.
  - WORD1: on output handshake, go to WORD2 if the command is two-word, else to IDLE.
  - WORD2: on output handshake, go to IDLE.
- in_value[15:0] and rt are latched on accept so the ORI word can be built without the input.
- in_ready = (state == IDLE) && !flush. Only one command is in flight at a time.
- out_valid is high in WORD1 and WORD2.
- out_last is high in WORD2, and in WORD1 for one-word commands.

## Timing
- Reset values: state IDLE, out_valid 0, out_instr 0x00000000, out_last 0. in_ready is 1 once reset is released.
- Latency: a command accepted at cycle N presents its first word at cycle N+1.
- On a WORD1 handshake of a two-word command, the ORI word appears at the next cycle. out_valid stays high with no bubble.
- While out_valid && !out_ready, out_instr and out_last hold stable.
- After the last handshake, in_ready is 1 on the next cycle. Peak rate is one one-word command per 2 cycles.
- A dropped rt = 0 command leaves out_valid at 0, and in_ready stays high on the following cycle.
- flush has priority over every handshake in the same cycle:
  - The next state is IDLE and out_valid is 0 next cycle.
  - An in-flight word, even one being handshaken that cycle, is not retired by the block.
  - A command presented in the flush cycle is not accepted.
- rst_n asserted mid-command clears everything immediately, regardless of the clock.

## Test plan
- ADDIU path: value 0x00001234, rt 8 -> one word 0x24081234 with last = 1. Value 0xFFFF8000, rt 9 -> 0x24098000 with last = 1.
- LUI-only path: value 0x12340000, rt 10 -> one word 0x3C0A1234 with last = 1.
- Two-word path with backpressure: value 0x12345678, rt 4, out_ready low for 3 cycles.
  - Expect 0x3C041234 (last 0) held stable throughout the stall.
  - Then 0x34845678 (last 1).
  - in_ready must stay 0 until the cycle after the final handshake.
- Sign boundary: value 0x00008000, rt 2 -> 0x3C020000 then 0x34428000. Value 0xFFFF7FFF, rt 3 -> 0x3C03FFFF then 0x34637FFF.
- rt = 0 handling:
  - EMIT_NOP_FOR_R0 = 0: no output, and in_ready is 1 on the next cycle.
  - EMIT_NOP_FOR_R0 = 1: exactly one 0x00000000 with last = 1.
- Flush and reset mid-command:
  - flush during WORD2 -> out_valid 0 next cycle, in_ready 1, and a following command is processed cleanly.
  - rst_n pulsed low between clock edges during WORD1 -> outputs at their reset values immediately.
